// File: rtl/lb4_seq_ctrl.sv
// lb4_seq_ctrl: sequencing controller for an external 4-bit up/down counter
// slice. It stores a reload value, direction and mode, steers the slice's
// load/enable/carry controls, and reports terminal events as a one-cycle TC
// pulse plus a saturating event count.
module lb4_seq_ctrl #(
  parameter int TCW = 8
) (
  input  logic           CK,
  input  logic           RSTN,
  input  logic           CMD_VALID,
  output logic           CMD_READY,
  input  logic [1:0]     CMD_OP,
  input  logic [3:0]     CMD_DATA,
  input  logic           CMD_DIR,
  input  logic           CMD_MODE,
  input  logic           TICK,
  input  logic [3:0]     Q,
  input  logic           CO,
  output logic [3:0]     D,
  output logic           SD,
  output logic           SP,
  output logic           CI,
  output logic           CON,
  output logic           CD,
  output logic           BUSY,
  output logic           TC,
  output logic [TCW-1:0] TC_CNT
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSED} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_START, OP_PAUSE, OP_ABORT} op_t;

  state_t         state_r, state_nx_s;
  logic [3:0]     reload_r;
  logic           dir_r, mode_r;
  logic           ready_r, busy_r, tc_r, cd_r;
  logic [TCW-1:0] cnt_r;

  logic acc_s, load_acc_s, start_s, pause_s, abort_s, term_s, tc_evt_s;
  logic sd_s, sp_s, ci_s;
  logic q_unused_s;

  // Terminal detection relies on the slice carry-out alone, so Q is not needed.
  assign q_unused_s = ^Q;

  assign acc_s      = CMD_VALID & ready_r;
  assign load_acc_s = acc_s & (CMD_OP == OP_LOAD) & (state_r == IDLE);
  assign start_s    = acc_s & (CMD_OP == OP_START);
  assign pause_s    = acc_s & (CMD_OP == OP_PAUSE);
  assign abort_s    = acc_s & (CMD_OP == OP_ABORT);
  // Slice carry-out matches direction exactly at the end of the count range.
  assign term_s     = (state_r == RUN) & TICK & (CO == dir_r);
  // An abort landing on the terminal cycle suppresses the event entirely.
  assign tc_evt_s   = term_s & ~abort_s;

  // Next-state selection and combinational slice controls.
  always_comb begin
    state_nx_s = state_r;
    sd_s       = 1'b0;
    sp_s       = 1'b0;
    ci_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_acc_s) begin
          state_nx_s = LOAD;
        end else if (start_s) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD: begin
        sd_s       = 1'b1;
        sp_s       = 1'b1;
        state_nx_s = IDLE;
      end
      RUN: begin
        if (term_s) begin
          if (abort_s) begin
            state_nx_s = IDLE;
          end else if (mode_r) begin
            // Periodic: reload instead of wrapping.
            sd_s       = 1'b1;
            sp_s       = 1'b1;
            ci_s       = dir_r;
            state_nx_s = pause_s ? PAUSED : RUN;
          end else begin
            // One-shot: hold the slice at its end value and stop.
            ci_s       = dir_r;
            state_nx_s = IDLE;
          end
        end else begin
          sp_s = TICK;
          ci_s = TICK & dir_r;
          if (abort_s) begin
            state_nx_s = IDLE;
          end else if (pause_s) begin
            state_nx_s = PAUSED;
          end else begin
            state_nx_s = RUN;
          end
        end
      end
      PAUSED: begin
        if (abort_s) begin
          state_nx_s = IDLE;
        end else if (start_s) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = PAUSED;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      tc_r    <= 1'b0;
      cd_r    <= 1'b1;
      cnt_r   <= {TCW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      ready_r <= (state_nx_s != LOAD);
      busy_r  <= (state_nx_s == RUN) || (state_nx_s == PAUSED);
      tc_r    <= tc_evt_s;
      cd_r    <= abort_s;
      if (load_acc_s) begin
        cnt_r <= {TCW{1'b0}};
      end else if (tc_evt_s && (cnt_r != {TCW{1'b1}})) begin
        cnt_r <= cnt_r + TCW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Configuration captured from an accepted LOAD in IDLE.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      reload_r <= 4'd0;
      dir_r    <= 1'b1;
      mode_r   <= 1'b0;
    end else if (load_acc_s) begin
      reload_r <= CMD_DATA;
      dir_r    <= CMD_DIR;
      mode_r   <= CMD_MODE;
    end else begin
      reload_r <= reload_r;
      dir_r    <= dir_r;
      mode_r   <= mode_r;
    end
  end

  assign CMD_READY = ready_r;
  assign D         = reload_r;
  assign CON       = dir_r;
  assign SD        = sd_s;
  assign SP        = sp_s;
  assign CI        = ci_s;
  assign CD        = cd_r;
  assign BUSY      = busy_r;
  assign TC        = tc_r;
  assign TC_CNT    = cnt_r;

endmodule

// File: tb/tb_lb4_seq_ctrl.sv
// Bench for lb4_seq_ctrl: two instances (default TCW and TCW=2) share the
// command stream, each drives its own behavioural 4-bit counter slice model.
module tb_lb4_seq_ctrl;

  localparam logic [1:0] LD = 2'd0, ST = 2'd1, PA = 2'd2, AB = 2'd3;

  logic       ck = 1'b0;
  logic       rstn, vld, dir, mode, tick;
  logic [1:0] op;
  logic [3:0] data;

  logic       rdy8, sd8, sp8, ci8, con8, cd8, busy8, tc8, co8;
  logic [3:0] d8;
  logic [7:0] cnt8;
  logic [3:0] q8 = 4'd0;

  logic       rdy2, sd2, sp2, ci2, con2, cd2, busy2, tc2, co2;
  logic [3:0] d2;
  logic [1:0] cnt2;
  logic [3:0] q2 = 4'd0;

  int total = 0;
  int bad   = 0;

  always #5 ck = ~ck;

  lb4_seq_ctrl dut8 (
    .CK(ck), .RSTN(rstn), .CMD_VALID(vld), .CMD_READY(rdy8), .CMD_OP(op),
    .CMD_DATA(data), .CMD_DIR(dir), .CMD_MODE(mode), .TICK(tick), .Q(q8),
    .CO(co8), .D(d8), .SD(sd8), .SP(sp8), .CI(ci8), .CON(con8), .CD(cd8),
    .BUSY(busy8), .TC(tc8), .TC_CNT(cnt8)
  );

  lb4_seq_ctrl #(.TCW(2)) dut2 (
    .CK(ck), .RSTN(rstn), .CMD_VALID(vld), .CMD_READY(rdy2), .CMD_OP(op),
    .CMD_DATA(data), .CMD_DIR(dir), .CMD_MODE(mode), .TICK(tick), .Q(q2),
    .CO(co2), .D(d2), .SD(sd2), .SP(sp2), .CI(ci2), .CON(con2), .CD(cd2),
    .BUSY(busy2), .TC(tc2), .TC_CNT(cnt2)
  );

  // Counter slice models: load D when SD, else step in direction CON.
  always @(posedge ck) begin
    if (sp8) q8 <= sd8 ? d8 : (con8 ? q8 + 4'd1 : q8 - 4'd1);
    if (sp2) q2 <= sd2 ? d2 : (con2 ? q2 + 4'd1 : q2 - 4'd1);
  end
  assign co8 = con8 ? (q8 == 4'd15) : (q8 != 4'd0);
  assign co2 = con2 ? (q2 == 4'd15) : (q2 != 4'd0);

  typedef struct {
    logic       rstn, vld;
    logic [1:0] op;
    logic [3:0] data;
    logic       dir, mode, tick;
    logic       sp, sd, ci;
    logic [3:0] q;
    logic       tc, busy, rdy, cd;
    logic [7:0] c8;
    logic [1:0] c2;
    logic [3:0] d;
    logic       con;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int r, v, o, dt, di, m, t, sp, sd, ci, q, tc, bs,
                     rd, cd, c8, c2, d, cn);
    vec_t x;
    x.rstn = r[0];  x.vld = v[0];  x.op = o[1:0];  x.data = dt[3:0];
    x.dir = di[0];  x.mode = m[0]; x.tick = t[0];
    x.sp = sp[0];   x.sd = sd[0];  x.ci = ci[0];   x.q = q[3:0];
    x.tc = tc[0];   x.busy = bs[0]; x.rdy = rd[0]; x.cd = cd[0];
    x.c8 = c8[7:0]; x.c2 = c2[1:0]; x.d = d[3:0];  x.con = cn[0];
    tbl.push_back(x);
  endtask

  task automatic chk(input int row, input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL row %0d %s: got %0d expected %0d", row, name, act, exp);
    end
  endtask

  task automatic drive(input logic r, v, input logic [1:0] o, input logic [3:0] dt,
                       input logic di, m, t);
    rstn = r; vld = v; op = o; data = dt; dir = di; mode = m; tick = t;
  endtask

  int n;
  logic seen;

  initial begin
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge ck);
    #1;

    //  rstn vld op dat dir mod tck | sp sd ci | q tc busy rdy cd | c8 c2 | d con
    add(0,0,0, 0,0,0,0, 0,0,0,  0,0,0,0,1, 0,0,  0,1); // reset held
    add(1,0,0, 0,0,0,0, 0,0,0,  0,0,0,1,0, 0,0,  0,1); // release
    add(1,1,LD,13,1,1,0, 0,0,0, 0,0,0,0,0, 0,0, 13,1); // LOAD 13 up periodic
    add(1,0,0, 0,0,0,0, 1,1,0, 13,0,0,1,0, 0,0, 13,1);
    add(1,1,ST,0,0,0,1, 0,0,0, 13,0,1,1,0, 0,0, 13,1);
    add(1,0,0, 0,0,0,1, 1,0,1, 14,0,1,1,0, 0,0, 13,1);
    add(1,0,0, 0,0,0,1, 1,0,1, 15,0,1,1,0, 0,0, 13,1);
    add(1,0,0, 0,0,0,1, 1,1,1, 13,1,1,1,0, 1,1, 13,1); // terminal -> reload
    add(1,0,0, 0,0,0,1, 1,0,1, 14,0,1,1,0, 1,1, 13,1);
    add(1,0,0, 0,0,0,1, 1,0,1, 15,0,1,1,0, 1,1, 13,1);
    add(1,0,0, 0,0,0,1, 1,1,1, 13,1,1,1,0, 2,2, 13,1);
    add(1,1,AB,0,0,0,0, 0,0,0, 13,0,0,1,1, 2,2, 13,1);
    add(1,0,0, 0,0,0,0, 0,0,0, 13,0,0,1,0, 2,2, 13,1);
    add(1,1,LD,2,0,0,0, 0,0,0, 13,0,0,0,0, 0,0,  2,0); // LOAD 2 down one-shot
    add(1,0,0, 0,0,0,0, 1,1,0,  2,0,0,1,0, 0,0,  2,0);
    add(1,1,ST,0,0,0,1, 0,0,0,  2,0,1,1,0, 0,0,  2,0);
    add(1,0,0, 0,0,0,1, 1,0,0,  1,0,1,1,0, 0,0,  2,0);
    add(1,0,0, 0,0,0,1, 1,0,0,  0,0,1,1,0, 0,0,  2,0);
    add(1,0,0, 0,0,0,1, 0,0,0,  0,1,0,1,0, 1,1,  2,0); // one-shot end
    add(1,0,0, 0,0,0,1, 0,0,0,  0,0,0,1,0, 1,1,  2,0);
    add(1,1,LD,5,1,0,0, 0,0,0,  0,0,0,0,0, 0,0,  5,1); // LOAD 5 up one-shot
    add(1,0,0, 0,0,0,0, 1,1,0,  5,0,0,1,0, 0,0,  5,1);
    add(1,1,ST,0,0,0,0, 0,0,0,  5,0,1,1,0, 0,0,  5,1);
    add(1,0,0, 0,0,0,1, 1,0,1,  6,0,1,1,0, 0,0,  5,1);
    add(1,0,0, 0,0,0,0, 0,0,0,  6,0,1,1,0, 0,0,  5,1);
    add(1,0,0, 0,0,0,1, 1,0,1,  7,0,1,1,0, 0,0,  5,1);
    add(1,1,PA,0,0,0,1, 1,0,1,  8,0,1,1,0, 0,0,  5,1); // PAUSE
    add(1,0,0, 0,0,0,1, 0,0,0,  8,0,1,1,0, 0,0,  5,1);
    add(1,0,0, 0,0,0,1, 0,0,0,  8,0,1,1,0, 0,0,  5,1);
    add(1,1,ST,0,0,0,1, 0,0,0,  8,0,1,1,0, 0,0,  5,1); // resume
    add(1,0,0, 0,0,0,1, 1,0,1,  9,0,1,1,0, 0,0,  5,1);
    add(1,1,AB,0,0,0,0, 0,0,0,  9,0,0,1,1, 0,0,  5,1);
    add(1,1,LD,15,1,1,0, 0,0,0, 9,0,0,0,0, 0,0, 15,1); // LOAD 15 up periodic
    add(1,0,0, 0,0,0,0, 1,1,0, 15,0,0,1,0, 0,0, 15,1);
    add(1,1,ST,0,0,0,0, 0,0,0, 15,0,1,1,0, 0,0, 15,1);
    add(1,1,AB,0,0,0,1, 0,0,0, 15,0,0,1,1, 0,0, 15,1); // abort on terminal
    add(1,0,0, 0,0,0,0, 0,0,0, 15,0,0,1,0, 0,0, 15,1);
    add(1,1,ST,0,0,0,0, 0,0,0, 15,0,1,1,0, 0,0, 15,1);
    add(1,0,0, 0,0,0,1, 1,1,1, 15,1,1,1,0, 1,1, 15,1);
    add(1,1,LD,3,0,0,1, 1,1,1, 15,1,1,1,0, 2,2, 15,1); // LOAD in RUN ignored
    add(1,0,0, 0,0,0,1, 1,1,1, 15,1,1,1,0, 3,3, 15,1);
    add(1,0,0, 0,0,0,1, 1,1,1, 15,1,1,1,0, 4,3, 15,1); // TCW=2 saturated
    add(1,0,0, 0,0,0,1, 1,1,1, 15,1,1,1,0, 5,3, 15,1);
    add(1,1,PA,0,0,0,0, 0,0,0, 15,0,1,1,0, 5,3, 15,1);
    add(1,1,ST,0,0,0,1, 0,0,0, 15,0,1,1,0, 5,3, 15,1);
    add(0,0,0, 0,0,0,1, 1,1,1, 15,0,0,0,1, 0,0,  0,1); // reset mid-RUN
    add(1,0,0, 0,0,0,0, 0,0,0, 15,0,0,1,0, 0,0,  0,1);

    foreach (tbl[i]) begin
      drive(tbl[i].rstn, tbl[i].vld, tbl[i].op, tbl[i].data,
            tbl[i].dir, tbl[i].mode, tbl[i].tick);
      #1;
      chk(i, "SP", int'(sp8), int'(tbl[i].sp));
      chk(i, "SD", int'(sd8), int'(tbl[i].sd));
      chk(i, "CI", int'(ci8), int'(tbl[i].ci));
      @(posedge ck);
      #1;
      chk(i, "Q",         int'(q8),    int'(tbl[i].q));
      chk(i, "TC",        int'(tc8),   int'(tbl[i].tc));
      chk(i, "BUSY",      int'(busy8), int'(tbl[i].busy));
      chk(i, "CMD_READY", int'(rdy8),  int'(tbl[i].rdy));
      chk(i, "CD",        int'(cd8),   int'(tbl[i].cd));
      chk(i, "TC_CNT",    int'(cnt8),  int'(tbl[i].c8));
      chk(i, "TC_CNT_w2", int'(cnt2),  int'(tbl[i].c2));
      chk(i, "D",         int'(d8),    int'(tbl[i].d));
      chk(i, "CON",       int'(con8),  int'(tbl[i].con));
    end

    // START while in LOAD (CMD_READY low) must be dropped.
    drive(1'b1, 1'b1, LD, 4'd7, 1'b1, 1'b0, 1'b0);
    @(posedge ck); #1;
    chk(100, "ready_in_load", int'(rdy8), 0);
    drive(1'b1, 1'b1, ST, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge ck); #1;
    chk(101, "q_after_load", int'(q8), 7);
    drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge ck); #1;
    chk(102, "start_dropped", int'(busy8), 0);

    // One-shot run from 7 up: terminal event after a bounded number of ticks.
    drive(1'b1, 1'b1, ST, 4'd0, 1'b0, 1'b0, 1'b1);
    @(posedge ck); #1;
    chk(103, "busy_start", int'(busy8), 1);
    drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge ck); #1;
      n++;
      if (tc8) begin
        seen = 1'b1;
        break;
      end
    end
    chk(104, "tc_seen", int'(seen), 1);
    chk(105, "ticks_to_tc", n, 9);
    chk(106, "busy_after_tc", int'(busy8), 0);
    chk(107, "cnt_after_tc", int'(cnt8), 1);
    chk(108, "q_hold_15", int'(q8), 15);
    @(posedge ck); #1;
    chk(109, "tc_one_cycle", int'(tc8), 0);
    chk(110, "q_still_15", int'(q8), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
